// File: rtl/spi_pkg.sv
// Purpose: shared widths and state encoding for the SPI master slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: DATA_W (frame width), BIT_CNT_W (bit counter width), state_t.
// Configuration macro used by importers: SPI_LSB_FIRST_EN.
package spi_pkg;

  localparam int DATA_W    = 8;
  localparam int BIT_CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// Purpose: divides mclk into the SPI clock and flags the edge about to happen.
// Latency: first sclk rise CLK_DIV mclk cycles after en goes high.
// Backpressure: none; sclk is forced low and the divider cleared whenever en is low.
//
// Ports:
//   mclk, reset      clock and async active-high reset
//   en               run the divider (high only while a frame is in flight)
//   sclk             SPI clock, idle low
//   sclk_rise/fall   combinational: sclk will rise/fall on the next mclk edge
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic mclk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             wrap;

  assign wrap      = en && (div_cnt == DIV_LAST);
  assign sclk_rise = wrap && !sclk;
  assign sclk_fall = wrap && sclk;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      // Holding the counter at zero means a new frame always starts a fresh half-period.
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Purpose: 8-bit SPI mode-0 master; host loads a byte, starts a frame, reads back the RX byte.
// Latency: cs low for 16*CLK_DIV mclk; one DONE cycle after; data_out valid the cycle after read.
// Backpressure: none; load/start/read are honoured only in IDLE and silently dropped otherwise.
//
// Ports:
//   mclk, reset             clock and async active-high reset
//   load, read, start       host commands (IDLE only, priority load > start > read)
//   data_in  [7:0]          TX byte captured on load
//   miso                    serial data from slave
//   data_out [7:0]          registered RX byte, updated on read
//   mosi, sclk, cs          SPI pins (sclk idle low, cs active low)
// Configuration: define SPI_LSB_FIRST_EN for LSB-first framing; default is MSB first.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              load,
  input  logic              read,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              miso,
  output logic [DATA_W-1:0] data_out,
  output logic              mosi,
  output logic              sclk,
  output logic              cs
);

  state_t state, state_nxt;

  logic [DATA_W-1:0]    tx_sr, tx_sr_nxt;
  logic [DATA_W-1:0]    rx_sr, rx_sr_nxt;
  logic [DATA_W-1:0]    rx_buf, rx_buf_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic                 cs_nxt, mosi_nxt;
  logic [DATA_W-1:0]    data_out_nxt;

  logic sclk_rise, sclk_fall, last_fall;

  // Bit-order specific views of the shift registers.
  logic              tx_first;  // bit driven when the frame opens
  logic              tx_next;   // bit driven after the current one is shifted out
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;

`ifdef SPI_LSB_FIRST_EN
  assign tx_first = tx_sr[0];
  assign tx_next  = tx_sr[1];
  assign tx_shift = {1'b0, tx_sr[DATA_W-1:1]};
  assign rx_shift = {miso, rx_sr[DATA_W-1:1]};
`else
  assign tx_first = tx_sr[DATA_W-1];
  assign tx_next  = tx_sr[DATA_W-2];
  assign tx_shift = {tx_sr[DATA_W-2:0], 1'b0};
  assign rx_shift = {rx_sr[DATA_W-2:0], miso};
`endif

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .mclk      (mclk),
    .reset     (reset),
    .en        (state == XFER),
    .sclk      (sclk),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  // The falling edge that completes the last bit closes the frame.
  assign last_fall = sclk_fall && (bit_cnt == BIT_CNT_W'(DATA_W - 1));

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!load && start) state_nxt = XFER;
      XFER:    if (last_fall)      state_nxt = DONE;
      DONE:                        state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_sr_nxt    = tx_sr;
    rx_sr_nxt    = rx_sr;
    rx_buf_nxt   = rx_buf;
    bit_cnt_nxt  = bit_cnt;
    cs_nxt       = cs;
    mosi_nxt     = mosi;
    data_out_nxt = data_out;
    case (state)
      IDLE: begin
        if (load) begin
          tx_sr_nxt = data_in;
        end else if (start) begin
          cs_nxt      = 1'b0;
          mosi_nxt    = tx_first;
          bit_cnt_nxt = '0;
        end else if (read) begin
          data_out_nxt = rx_buf;
        end
      end
      XFER: begin
        if (sclk_rise) rx_sr_nxt = rx_shift;
        if (sclk_fall) begin
          tx_sr_nxt   = tx_shift;
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (last_fall) begin
            cs_nxt     = 1'b1;
            mosi_nxt   = 1'b0;
            rx_buf_nxt = rx_sr;
          end else begin
            mosi_nxt = tx_next;
          end
        end
      end
      DONE: mosi_nxt = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_buf   <= '0;
      bit_cnt  <= '0;
      cs       <= 1'b1;
      mosi     <= 1'b0;
      data_out <= '0;
    end else begin
      tx_sr    <= tx_sr_nxt;
      rx_sr    <= rx_sr_nxt;
      rx_buf   <= rx_buf_nxt;
      bit_cnt  <= bit_cnt_nxt;
      cs       <= cs_nxt;
      mosi     <= mosi_nxt;
      data_out <= data_out_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Purpose: self-checking bench for spi_master_ctrl: vector table, corner sequences, random frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_master_ctrl;

  localparam int CLK_DIV   = 2;
  localparam int FRAME_CYC = 16 * CLK_DIV;

  logic       mclk = 1'b0;
  logic       reset, load, read, start;
  logic [7:0] data_in;
  logic       miso;
  logic [7:0] data_out;
  logic       mosi, sclk, cs;

  always #5 mclk = ~mclk;

  spi_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .mclk     (mclk),
    .reset    (reset),
    .load     (load),
    .read     (read),
    .start    (start),
    .data_in  (data_in),
    .miso     (miso),
    .data_out (data_out),
    .mosi     (mosi),
    .sclk     (sclk),
    .cs       (cs)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Order of bits on the wire: element i is the bit carried by sclk rise i.
  function automatic logic [7:0] line_order(input logic [7:0] b);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) begin
`ifdef SPI_LSB_FIRST_EN
      w[i] = b[i];
`else
      w[i] = b[7-i];
`endif
    end
    return w;
  endfunction

  // ---------------- slave model and bus monitor ----------------
  logic [7:0] slv_byte   = 8'h00;
  int         rise_cnt   = 8;
  int         cs_low_cnt = 0;
  int         first_rise = -1;
  int         frames     = 0;
  int         dones      = 0;
  int         sclk_viol  = 0;
  int         mosi_viol  = 0;
  logic [7:0] mosi_bits  = 8'h00;
  logic       prev_cs    = 1'b1;
  logic       prev_sclk  = 1'b0;
  logic       prev_mosi  = 1'b0;

  logic [7:0] slv_line;
  assign slv_line = line_order(slv_byte);
  assign miso     = (rise_cnt < 8) ? slv_line[rise_cnt[2:0]] : 1'b0;

  always @(negedge mclk) begin
    if (!cs && prev_cs) begin
      frames++;
      cs_low_cnt = 0;
      rise_cnt   = 0;
      first_rise = -1;
      mosi_bits  = 8'h00;
    end
    if (!cs) cs_low_cnt++;
    if (cs && !prev_cs) dones++;
    if (cs && sclk) sclk_viol++;
    if (!cs && sclk && !prev_sclk) begin
      if (rise_cnt == 0) first_rise = cs_low_cnt - 1;
      if (rise_cnt < 8) mosi_bits[rise_cnt[2:0]] = mosi;
      rise_cnt++;
    end
    // mosi may only move together with a falling sclk while the frame is open.
    if (!cs && !prev_cs && (mosi !== prev_mosi) && !(prev_sclk && !sclk)) mosi_viol++;
    prev_cs   = cs;
    prev_sclk = sclk;
    prev_mosi = mosi;
  end

  // ---------------- reference model state ----------------
  logic [7:0] m_tx, m_rxbuf, m_dout;

  task automatic tick();
    @(negedge mclk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] b);
    load = 1'b1; data_in = b;
    tick();
    load = 1'b0;
    m_tx = b;
  endtask

  task automatic do_read(input string tag);
    read = 1'b1;
    tick();
    read = 1'b0;
    m_dout = m_rxbuf;
    check({tag, " data_out after read"}, data_out, m_dout);
  endtask

  task automatic begin_frame(input logic [7:0] slv);
    slv_byte = slv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_frame(input string tag, input int f0);
    int d0, n;
    d0 = dones;
    n  = 0;
    while (dones == d0 && cs == 1'b0 && n < FRAME_CYC + 10) begin
      tick();
      n++;
    end
    check({tag, " frame completed"}, (dones != d0) ? 1 : 0, 1);
    check({tag, " one frame"},        frames - f0, 1);
    check({tag, " mosi bits"},        mosi_bits, line_order(m_tx));
    check({tag, " sclk rises"},       rise_cnt, 8);
    check({tag, " cs low cycles"},    cs_low_cnt, FRAME_CYC);
    check({tag, " first rise delay"}, first_rise, CLK_DIV);
    m_rxbuf = slv_byte;
    m_tx    = 8'h00;  // the TX byte is consumed by the frame
    tick();           // let the DONE cycle pass
    check({tag, " data_out held"}, data_out, m_dout);
  endtask

  task automatic run_frame(input logic [7:0] slv, input string tag);
    int f0;
    f0 = frames;
    begin_frame(slv);
    end_frame(tag, f0);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slv;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int f0, n;
    vecs[0] = '{tx: 8'hA5, slv: 8'h3C, exp_dout: 8'h3C};
    vecs[1] = '{tx: 8'h00, slv: 8'hFF, exp_dout: 8'hFF};
    vecs[2] = '{tx: 8'hFF, slv: 8'h00, exp_dout: 8'h00};
    vecs[3] = '{tx: 8'h81, slv: 8'h7E, exp_dout: 8'h7E};
    vecs[4] = '{tx: 8'h01, slv: 8'h01, exp_dout: 8'h01};

    reset = 1'b1; load = 1'b0; read = 1'b0; start = 1'b0; data_in = 8'h00;
    m_tx = 8'h00; m_rxbuf = 8'h00; m_dout = 8'h00;
    #1;
    check("reset cs", cs, 1);
    check("reset sclk", sclk, 0);
    check("reset mosi", mosi, 0);
    check("reset data_out", data_out, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Vector table: load, frame, data_out untouched until read, then read.
    for (int i = 0; i < 5; i++) begin
      do_load(vecs[i].tx);
      run_frame(vecs[i].slv, $sformatf("vec%0d", i));
      do_read($sformatf("vec%0d", i));
      check($sformatf("vec%0d expected data_out", i), data_out, vecs[i].exp_dout);
    end

    // A5 on the wire: explicit bit sequence seen at successive rises.
    do_load(8'hA5);
    run_frame(8'h3C, "a5");
`ifdef SPI_LSB_FIRST_EN
    check("a5 wire sequence", mosi_bits, 8'b1010_0101);
`else
    check("a5 wire sequence", mosi_bits, 8'b1010_0101);
`endif
    do_read("a5");

    // Commands during XFER are ignored; the original byte goes out and no frame follows.
    do_load(8'hA5);
    f0 = frames;
    begin_frame(8'h96);
    for (int i = 0; i < 10; i++) begin
      load = 1'b1; data_in = 8'hFF; start = 1'b1; read = 1'b1;
      tick();
    end
    load = 1'b0; start = 1'b0; read = 1'b0;
    check("xfer read ignored", data_out, m_dout);
    end_frame("xfer_cmds", f0);
    repeat (40) tick();
    check("xfer start no second frame", frames - f0, 1);
    // data_in (and the FF offered mid-frame) is not retained: a bare start sends zeros.
    run_frame(8'h11, "no_reload");
    do_read("no_reload");

    // Load and read in the same IDLE cycle: load wins, data_out keeps its value.
    do_load(8'h3A);
    run_frame(8'hC3, "pre_lr");
    load = 1'b1; read = 1'b1; data_in = 8'h96;
    tick();
    load = 1'b0; read = 1'b0; m_tx = 8'h96;
    check("load+read data_out unchanged", data_out, m_dout);
    run_frame(8'h5A, "after_lr");
    do_read("after_lr");

    // Load and start in the same cycle: start is dropped.
    f0 = frames;
    load = 1'b1; start = 1'b1; data_in = 8'h4D;
    tick();
    load = 1'b0; start = 1'b0; m_tx = 8'h4D;
    repeat (5) tick();
    check("load+start no frame", frames - f0, 0);
    run_frame(8'hE7, "after_ls");
    do_read("after_ls");

    // Randomised frames against the model.
    for (int i = 0; i < 16; i++) begin
      do_load(8'($urandom));
      run_frame(8'($urandom), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) do_read($sformatf("rnd%0d", i));
    end

    // Async reset mid-frame, after the third sclk rise, between clock edges.
    do_load(8'hFF);
    run_frame(8'hA9, "pre_rst");
    do_read("pre_rst");
    do_load(8'hFF);
    begin_frame(8'h00);
    n = 0;
    while (rise_cnt < 3 && n < FRAME_CYC) begin
      tick();
      n++;
    end
    check("mid-frame reached 3 rises", rise_cnt, 3);
    check("mid-frame sclk high", sclk, 1);
    check("mid-frame mosi high", mosi, 1);
    #1 reset = 1'b1;
    #1;
    check("async reset cs", cs, 1);
    check("async reset sclk", sclk, 0);
    check("async reset mosi", mosi, 0);
    check("async reset data_out", data_out, 0);
    tick();
    reset = 1'b0;
    m_tx = 8'h00; m_rxbuf = 8'h00; m_dout = 8'h00;
    tick();
    do_read("post_rst");
    run_frame(8'h00, "post_rst_cleared_tx");

    check("sclk low whenever cs high", sclk_viol, 0);
    check("mosi stable around rises", mosi_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
